// File: rtl/wb_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wbf_pkg
// Brief    : Shared types and helpers for the write-back / fetch stage.
// Revision : 1.0
// ============================================================================
package wbf_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } load_size_e;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } wb_state_e;

    localparam int unsigned c_word_w = 32;

    function automatic int unsigned bytes_f(input logic [1:0] size);
        case (size)
            LS_BYTE: return 1;
            LS_HALF: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned beats_f(input logic [1:0] size, input int unsigned mem_w);
        int unsigned n;
        n = (8 * bytes_f(size)) / mem_w;
        return (n == 0) ? 1 : n;
    endfunction

    // Encoding 2'b11 falls into the word case.
    function automatic logic [c_word_w-1:0] extend_f(input logic [c_word_w-1:0] data,
                                                     input logic [1:0]          size,
                                                     input logic                is_signed);
        case (size)
            LS_BYTE: return is_signed ? {{24{data[7]}}, data[7:0]}   : {24'd0, data[7:0]};
            LS_HALF: return is_signed ? {{16{data[15]}}, data[15:0]} : {16'd0, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_fetch_stage_if
// Brief    : Bus bundle between the pipeline and the write-back / fetch stage.
// Revision : 1.0
// ============================================================================
interface wb_fetch_stage_if #(
    parameter int XLEN  = 32,
    parameter int MEM_W = 16
);
    logic [MEM_W-1:0] data_read_i;
    logic [XLEN-1:0]  data_calc_i;
    logic             load_req_i;
    logic [1:0]       load_size_i;
    logic             load_signed_i;
    logic             instr_mem_en_i;
    logic             stall_fetch_i;
    logic             stall_pc_i;
    logic             branch_i;
    logic [XLEN-1:0]  branch_pc_i;
    logic [XLEN-1:0]  instr_mem_addr_o;
    logic             instr_mem_re_o;
    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  next_pc_o;
    logic [XLEN-1:0]  write_back_o;
    logic             wb_valid_o;
    logic             load_busy_o;

    modport master (
        output data_read_i, data_calc_i, load_req_i, load_size_i, load_signed_i,
               instr_mem_en_i, stall_fetch_i, stall_pc_i, branch_i, branch_pc_i,
        input  instr_mem_addr_o, instr_mem_re_o, pc_o, next_pc_o,
               write_back_o, wb_valid_o, load_busy_o
    );

    modport slave (
        input  data_read_i, data_calc_i, load_req_i, load_size_i, load_signed_i,
               instr_mem_en_i, stall_fetch_i, stall_pc_i, branch_i, branch_pc_i,
        output instr_mem_addr_o, instr_mem_re_o, pc_o, next_pc_o,
               write_back_o, wb_valid_o, load_busy_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_fetch_stage_load_assembler.sv
`default_nettype none
// ============================================================================
// Module   : load_assembler
// Brief    : Collects 1..N little-endian beats of a load and extends the result.
// Revision : 1.0
// ============================================================================
module load_assembler
    import wbf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int MEM_W = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic [MEM_W-1:0] i_data,
    input  wire logic             i_req,
    input  wire logic [1:0]       i_size,
    input  wire logic             i_signed,
    output logic      [XLEN-1:0]  o_data,
    output logic                  o_valid,
    output logic                  o_busy
);

    wb_state_e     r_state, w_state_nxt;
    logic [1:0]    r_cnt, w_cnt_nxt;
    logic [31:0]   r_cap, w_cap_nxt;
    logic [1:0]    r_size, w_size_nxt;
    logic          r_signed, w_signed_nxt;

    logic [31:0]   w_beat;
    logic [5:0]    w_off;
    logic [31:0]   w_assembled;
    logic [1:0]    w_size_eff;
    logic          w_signed_eff;
    logic [31:0]   w_ext;

    assign w_beat = 32'(i_data);
    assign w_off  = 6'(r_cnt) * 6'(MEM_W);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cap_nxt    = r_cap;
        w_size_nxt   = r_size;
        w_signed_nxt = r_signed;
        w_assembled  = w_beat;
        w_size_eff   = i_size;
        w_signed_eff = i_signed;
        o_valid      = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req) begin
                    if (beats_f(i_size, MEM_W) == 1) begin
                        o_valid = 1'b1;
                    end else begin
                        w_state_nxt  = COLLECT;
                        w_cnt_nxt    = 2'd1;
                        w_cap_nxt    = w_beat;
                        w_size_nxt   = i_size;
                        w_signed_nxt = i_signed;
                    end
                end
            end
            COLLECT: begin
                // Size/sign come from the latched request; new requests are ignored here.
                o_busy       = 1'b1;
                w_size_eff   = r_size;
                w_signed_eff = r_signed;
                w_assembled  = r_cap | (w_beat << w_off);
                w_cap_nxt    = w_assembled;
                w_cnt_nxt    = r_cnt + 2'd1;
                if (32'(r_cnt) == beats_f(r_size, MEM_W) - 1) begin
                    o_valid     = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 2'd0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_ext = extend_f(w_assembled, w_size_eff, w_signed_eff);

    generate
        if (XLEN > 32) begin : g_wide
            logic w_fill;
            assign w_fill = w_signed_eff & w_ext[31];
            assign o_data = {{(XLEN-32){w_fill}}, w_ext};
        end else begin : g_narrow
            assign o_data = w_ext[XLEN-1:0];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_cnt    <= 2'd0;
            r_cap    <= 32'd0;
            r_size   <= 2'd0;
            r_signed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cap    <= w_cap_nxt;
            r_size   <= w_size_nxt;
            r_signed <= w_signed_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_fetch_stage
// Brief    : Load write-back assembly plus PC / instruction-fetch control.
// Revision : 1.0
// ============================================================================
module wb_fetch_stage
    import wbf_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          MEM_W    = 16,
    parameter int unsigned PC_STEP  = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    wb_fetch_stage_if.slave  bus
);

    generate
        if ((XLEN % MEM_W) != 0 || !(MEM_W == 8 || MEM_W == 16 || MEM_W == 32) || XLEN < 32)
        begin : g_bad_params
            $error("wb_fetch_stage: unsupported XLEN/MEM_W combination");
        end
    endgenerate

    logic [XLEN-1:0] w_ld_data;
    logic            w_ld_valid;
    logic            w_ld_busy;

    load_assembler #(
        .XLEN  (XLEN),
        .MEM_W (MEM_W)
    ) u_load_asm (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_data   (bus.data_read_i),
        .i_req    (bus.load_req_i),
        .i_size   (bus.load_size_i),
        .i_signed (bus.load_signed_i),
        .o_data   (w_ld_data),
        .o_valid  (w_ld_valid),
        .o_busy   (w_ld_busy)
    );

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic            r_pend;
    logic [XLEN-1:0] w_next_pc;
    logic            w_freeze;
    logic            w_update;
    logic            w_wb_valid;

    assign w_freeze = bus.stall_pc_i | w_ld_busy;
    assign w_update = bus.instr_mem_en_i & ~w_freeze;

    always_comb begin
        w_next_pc = r_pc + XLEN'(PC_STEP);
        if (bus.branch_i) begin
            w_next_pc = bus.branch_pc_i;
        end else if (r_pend) begin
            w_next_pc = r_pend_pc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc      <= XLEN'(RESET_PC);
            r_pend_pc <= '0;
            r_pend    <= 1'b0;
        end else if (w_update) begin
            r_pc   <= w_next_pc;
            r_pend <= 1'b0;
        end else if (bus.branch_i && w_freeze) begin
            // Keep the newest frozen-time branch until the PC may move again.
            r_pend_pc <= bus.branch_pc_i;
            r_pend    <= 1'b1;
        end
    end

    // The IDLE single-beat path is combinational, so mask it while reset is held.
    assign w_wb_valid = rst_ni & w_ld_valid;

    assign bus.pc_o             = r_pc;
    assign bus.instr_mem_addr_o = r_pc;
    assign bus.next_pc_o        = w_next_pc;
    assign bus.instr_mem_re_o   = rst_ni & ~bus.stall_fetch_i;
    assign bus.wb_valid_o       = w_wb_valid;
    assign bus.load_busy_o      = w_ld_busy;
    assign bus.write_back_o     = w_wb_valid ? w_ld_data : bus.data_calc_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_fetch_stage
// Brief    : Scoreboard bench for wb_fetch_stage with 16-bit and 8-bit beats.
// Revision : 1.0
// ============================================================================
module tb_wb_fetch_stage;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    logic [31:0] q16[$];
    logic [31:0] q8[$];

    wb_fetch_stage_if #(.XLEN(32), .MEM_W(16)) bus16 ();
    wb_fetch_stage_if #(.XLEN(32), .MEM_W(8))  bus8  ();

    wb_fetch_stage #(.XLEN(32), .MEM_W(16), .PC_STEP(2), .RESET_PC(0)) u_dut16 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus16)
    );

    wb_fetch_stage #(.XLEN(32), .MEM_W(8), .PC_STEP(2), .RESET_PC(0)) u_dut8 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid write-back must match the oldest expected value.
    always @(negedge clk) begin
        if (bus16.wb_valid_o === 1'b1) begin
            if (q16.size() == 0) check("wb16_valid_unexpected", {31'd0, bus16.wb_valid_o}, 32'd0);
            else                 check("wb16_data", bus16.write_back_o, q16.pop_front());
        end
        if (bus8.wb_valid_o === 1'b1) begin
            if (q8.size() == 0) check("wb8_valid_unexpected", {31'd0, bus8.wb_valid_o}, 32'd0);
            else                check("wb8_data", bus8.write_back_o, q8.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        {bus16.data_read_i, bus16.data_calc_i, bus16.load_req_i, bus16.load_size_i,
         bus16.load_signed_i, bus16.instr_mem_en_i, bus16.stall_fetch_i, bus16.stall_pc_i,
         bus16.branch_i, bus16.branch_pc_i} = '0;
        {bus8.data_read_i, bus8.data_calc_i, bus8.load_req_i, bus8.load_size_i,
         bus8.load_signed_i, bus8.instr_mem_en_i, bus8.stall_fetch_i, bus8.stall_pc_i,
         bus8.branch_i, bus8.branch_pc_i} = '0;
        // A byte request held during reset must not produce a valid write-back.
        bus16.load_req_i = 1'b1;
        bus16.data_read_i = 16'h00AA;

        repeat (2) @(negedge clk);
        check("rst_pc16",    bus16.pc_o, 32'd0);
        check("rst_addr16",  bus16.instr_mem_addr_o, 32'd0);
        check("rst_re16",    {31'd0, bus16.instr_mem_re_o}, 32'd0);
        check("rst_valid16", {31'd0, bus16.wb_valid_o}, 32'd0);
        check("rst_busy16",  {31'd0, bus16.load_busy_o}, 32'd0);
        check("rst_pc8",     bus8.pc_o, 32'd0);
        bus16.load_req_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("run_re16", {31'd0, bus16.instr_mem_re_o}, 32'd1);

        // Half load, signed, single beat.
        tick();
        bus16.load_req_i = 1'b1; bus16.load_size_i = 2'b01; bus16.load_signed_i = 1'b1;
        bus16.data_read_i = 16'h8001;
        q16.push_back(32'hFFFF_8001);
        @(negedge clk);
        check("t1_busy", {31'd0, bus16.load_busy_o}, 32'd0);
        tick();
        bus16.load_req_i = 1'b0; bus16.data_calc_i = 32'hCAFE_0001;
        @(negedge clk);
        check("t1_calc_pass", bus16.write_back_o, 32'hCAFE_0001);

        // Word load over two 16-bit beats with fetch enabled.
        tick();
        bus16.instr_mem_en_i = 1'b1;
        bus16.load_req_i = 1'b1; bus16.load_size_i = 2'b10; bus16.load_signed_i = 1'b0;
        bus16.data_read_i = 16'h5678;
        q16.push_back(32'h1234_5678);
        @(negedge clk);
        check("t2_busy_a", {31'd0, bus16.load_busy_o}, 32'd0);
        check("t2_pc_a",   bus16.pc_o, 32'h0);
        tick();
        bus16.load_req_i = 1'b0; bus16.data_read_i = 16'h1234;
        @(negedge clk);
        check("t2_busy_b", {31'd0, bus16.load_busy_o}, 32'd1);
        check("t2_pc_b",   bus16.pc_o, 32'h2);
        tick();
        @(negedge clk);
        check("t2_busy_c", {31'd0, bus16.load_busy_o}, 32'd0);
        check("t2_pc_held", bus16.pc_o, 32'h2);
        tick();
        bus16.instr_mem_en_i = 1'b0;

        // Word load over four 8-bit beats; a mid-load request must be ignored.
        bus8.instr_mem_en_i = 1'b1;
        bus8.load_req_i = 1'b1; bus8.load_size_i = 2'b10; bus8.load_signed_i = 1'b0;
        bus8.data_read_i = 8'h11;
        q8.push_back(32'h4433_2211);
        @(negedge clk);
        check("t3_busy_a", {31'd0, bus8.load_busy_o}, 32'd0);
        check("t3_pc_a",   bus8.pc_o, 32'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            bus8.data_read_i = 8'(8'h11 * (i + 1));
            bus8.load_req_i  = (i == 1);
            if (i == 1) begin
                bus8.load_size_i = 2'b00; bus8.load_signed_i = 1'b1;
            end
            @(negedge clk);
            check($sformatf("t3_busy_%0d", i), {31'd0, bus8.load_busy_o}, 32'd1);
            check($sformatf("t3_pc_%0d", i),   bus8.pc_o, 32'h2);
        end
        tick();
        bus8.load_req_i = 1'b0;
        @(negedge clk);
        check("t3_busy_e", {31'd0, bus8.load_busy_o}, 32'd0);
        check("t3_pc_e",   bus8.pc_o, 32'h2);
        tick();
        bus8.instr_mem_en_i = 1'b0;

        // Branch to 0x10, then a branch arriving on the final beat of a load.
        bus16.branch_i = 1'b1; bus16.branch_pc_i = 32'h10; bus16.instr_mem_en_i = 1'b1;
        @(negedge clk);
        check("t4_next_br", bus16.next_pc_o, 32'h10);
        tick();
        bus16.branch_i = 1'b0; bus16.instr_mem_en_i = 1'b0;
        bus16.load_req_i = 1'b1; bus16.load_size_i = 2'b10; bus16.load_signed_i = 1'b1;
        bus16.data_read_i = 16'hBEEF;
        q16.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        check("t4_pc_start", bus16.pc_o, 32'h10);
        tick();
        bus16.load_req_i = 1'b0; bus16.data_read_i = 16'hDEAD;
        bus16.branch_i = 1'b1; bus16.branch_pc_i = 32'h200;
        @(negedge clk);
        check("t4_busy",    {31'd0, bus16.load_busy_o}, 32'd1);
        check("t4_pc_frz",  bus16.pc_o, 32'h10);
        tick();
        bus16.branch_i = 1'b0; bus16.branch_pc_i = 32'h0;
        @(negedge clk);
        check("t4_pc_hold", bus16.pc_o, 32'h10);
        check("t4_next_pend", bus16.next_pc_o, 32'h200);
        tick();
        bus16.instr_mem_en_i = 1'b1;
        tick();
        @(negedge clk);
        check("t4_pc_br",   bus16.pc_o, 32'h200);
        check("t4_next_seq", bus16.next_pc_o, 32'h202);
        tick();
        @(negedge clk);
        check("t4_pc_seq",  bus16.pc_o, 32'h202);

        // PC wrap at the top of the address space, then fetch stall.
        tick();
        bus16.branch_i = 1'b1; bus16.branch_pc_i = 32'hFFFF_FFFE;
        tick();
        bus16.branch_i = 1'b0;
        @(negedge clk);
        check("t6_pc_top",   bus16.pc_o, 32'hFFFF_FFFE);
        check("t6_next_wrap", bus16.next_pc_o, 32'h0);
        tick();
        bus16.instr_mem_en_i = 1'b0; bus16.stall_fetch_i = 1'b1;
        @(negedge clk);
        check("t6_pc_wrap", bus16.pc_o, 32'h0);
        check("t6_re_stall", {31'd0, bus16.instr_mem_re_o}, 32'd0);
        tick();
        bus16.stall_fetch_i = 1'b0;

        // Asynchronous reset in the middle of a multi-beat load.
        bus16.instr_mem_en_i = 1'b1;
        bus16.load_req_i = 1'b1; bus16.load_size_i = 2'b10; bus16.data_read_i = 16'h1111;
        tick();
        bus16.load_req_i = 1'b0; bus16.data_read_i = 16'h2222;
        check("t5_busy_pre", {31'd0, bus16.load_busy_o}, 32'd1);
        check("t5_pc_pre",   bus16.pc_o, 32'h2);
        #2;
        rst_n = 1'b0;
        bus16.instr_mem_en_i = 1'b0;
        #1;
        check("t5_busy_async",  {31'd0, bus16.load_busy_o}, 32'd0);
        check("t5_pc_async",    bus16.pc_o, 32'h0);
        check("t5_valid_async", {31'd0, bus16.wb_valid_o}, 32'd0);
        check("t5_re_async",    {31'd0, bus16.instr_mem_re_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_pc_post",   bus16.pc_o, 32'h0);
        check("t5_busy_post", {31'd0, bus16.load_busy_o}, 32'd0);
        check("t5_wb_post",   bus16.write_back_o, 32'hCAFE_0001);

        check("q16_drained", 32'(q16.size()), 32'd0);
        check("q8_drained",  32'(q8.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
